// File: rtl/alu_mc_param.sv
// Handshaked MIPS ALU: single-cycle logic/arith/slt ops and a WIDTH-cycle shift-add
// unsigned multiply. Results and flags stay registered until the consumer takes them.
module alu_mc_param #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_ctr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r_hi,
  output logic             c_out,
  output logic             ovf,
  output logic             z,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, MUL} state_t;
  typedef struct packed {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             c;
    logic             v;
    logic             z;
  } res_t;

  state_t               state_q, state_d;
  res_t                 res_q, res_d, alu_res;
  logic                 out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d, acc_step;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 accept, is_mul, sub_op;
  logic [WIDTH-1:0]     b_x;
  logic [WIDTH:0]       sum;

  // rst_n gates in_ready so nothing is offered as acceptable while held in reset
  assign in_ready = rst_n & (state_q == IDLE) & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign is_mul   = (MUL_EN == 1'b1) && (alu_ctr == 3'b100);

  always_comb begin
    sub_op  = (alu_ctr == 3'b110);
    b_x     = sub_op ? ~b : b;
    sum     = {1'b0, a} + {1'b0, b_x} + {{WIDTH{1'b0}}, sub_op};
    alu_res = '0;
    case (alu_ctr)
      3'b000: alu_res.lo = a & b;
      3'b001: alu_res.lo = a | b;
      3'b010, 3'b110: begin
        alu_res.lo = sum[WIDTH-1:0];
        alu_res.c  = sum[WIDTH];
        alu_res.v  = (a[WIDTH-1] == b_x[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
      end
      3'b011: alu_res.lo = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      3'b101: alu_res.lo = ~(a | b);
      3'b111: alu_res.lo = a ^ b;
      default: ;  // mul without the multiplier yields all-zero
    endcase
    alu_res.z = (alu_res.lo == '0);
  end

  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_d  = MUL;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = '0;
          end else begin
            res_d       = alu_res;
            out_valid_d = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d     = IDLE;
          res_d       = '0;
          res_d.hi    = acc_step[2*WIDTH-1:WIDTH];
          res_d.lo    = acc_step[WIDTH-1:0];
          res_d.z     = (acc_step == '0);
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign r         = res_q.lo;
  assign r_hi      = res_q.hi;
  assign c_out     = res_q.c;
  assign ovf       = res_q.v;
  assign z         = res_q.z;
  assign busy      = (state_q == MUL);
endmodule
